// File: rtl/lcd_write_ctrl.sv
// Buffers LSU stores to the LCD register in a small FIFO and replays each
// word onto an HD44780-style character LCD with setup/enable/hold/exec timing.
module lcd_write_ctrl #(
    parameter int FIFO_DEPTH  = 4,
    parameter int T_SETUP     = 2,
    parameter int T_EN_HIGH   = 12,
    parameter int T_HOLD      = 2,
    parameter int T_EXEC      = 2000,
    parameter int T_EXEC_LONG = 82000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        lcd_wr_i,
    input  logic [31:0] lcd_word_i,
    output logic        lcd_on_o,
    output logic        lcd_rs_o,
    output logic        lcd_rw_o,
    output logic        lcd_en_o,
    output logic [7:0]  lcd_data_o,
    output logic [31:0] status_o,
    input  logic        ovf_clr_i
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(T_EXEC_LONG + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_PULSE,
        S_HOLD,
        S_WAIT
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   cnt_q, cnt_d;
    logic [8:0]      mem [FIFO_DEPTH];
    logic [AW-1:0]   rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic            rs_q, on_q, en_q;
    logic [7:0]      data_q;
    logic [31:0]     status_q;
    logic            push, pop, long_cmd;
    logic            busy_d, full_d, empty_d;
    logic [3:0]      count4_d;
    logic            unused_word;

    assign unused_word = ^{lcd_word_i[30:10], lcd_word_i[8]};

    // A push into a full FIFO is still accepted when the head leaves this cycle.
    assign pop  = (state_q == S_IDLE) && (count_q != '0);
    assign push = lcd_wr_i && ((count_q < CW'(FIFO_DEPTH)) || pop);

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        ovf_d = ovf_q;
        if (ovf_clr_i) ovf_d = 1'b0;
        if (lcd_wr_i && !push) ovf_d = 1'b1;
    end

    assign long_cmd = !rs_q && ((data_q == 8'h01) || (data_q == 8'h02) || (data_q == 8'h03));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    state_d = S_SETUP;
                    cnt_d   = TW'(T_SETUP - 1);
                end
            end
            S_SETUP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE;
                    cnt_d   = TW'(T_EN_HIGH - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_PULSE: begin
                if (cnt_q == '0) begin
                    state_d = S_HOLD;
                    cnt_d   = TW'(T_HOLD - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_HOLD: begin
                if (cnt_q == '0) begin
                    state_d = S_WAIT;
                    cnt_d   = long_cmd ? TW'(T_EXEC_LONG - 1) : TW'(T_EXEC - 1);
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign busy_d   = (state_d != S_IDLE) || (count_d != '0);
    assign full_d   = (count_d == CW'(FIFO_DEPTH));
    assign empty_d  = (count_d == '0);
    assign count4_d = 4'(count_d);

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr_q] <= {lcd_word_i[9], lcd_word_i[7:0]};
    end

    // Status is computed from next-state values so it mirrors the registers
    // as of the most recent edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            rs_q     <= 1'b0;
            data_q   <= 8'h00;
            on_q     <= 1'b0;
            en_q     <= 1'b0;
            status_q <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            en_q    <= (state_d == S_PULSE);
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop) begin
                rd_ptr_q         <= rd_ptr_q + 1'b1;
                {rs_q, data_q}   <= mem[rd_ptr_q];
            end
            if (lcd_wr_i) on_q <= lcd_word_i[31];
            status_q <= {24'h0, count4_d, empty_d, ovf_d, full_d, busy_d};
        end
    end

    assign lcd_on_o   = on_q;
    assign lcd_rs_o   = rs_q;
    assign lcd_rw_o   = 1'b0;
    assign lcd_en_o   = en_q;
    assign lcd_data_o = data_q;
    assign status_o   = status_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Scoreboard bench for lcd_write_ctrl: expected {gap, RS, DATA} per EN pulse is
// queued at stimulus time and checked by a monitor on every EN rising edge.
module tb_lcd_write_ctrl;

    localparam int FIFO_DEPTH  = 4;
    localparam int T_SETUP     = 1;
    localparam int T_EN_HIGH   = 2;
    localparam int T_HOLD      = 1;
    localparam int T_EXEC      = 4;
    localparam int T_EXEC_LONG = 10;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        lcd_wr_i = 1'b0;
    logic [31:0] lcd_word_i = 32'h0;
    logic        ovf_clr_i = 1'b0;
    logic        lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o;
    logic [7:0]  lcd_data_o;
    logic [31:0] status_o;

    lcd_write_ctrl #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .T_SETUP    (T_SETUP),
        .T_EN_HIGH  (T_EN_HIGH),
        .T_HOLD     (T_HOLD),
        .T_EXEC     (T_EXEC),
        .T_EXEC_LONG(T_EXEC_LONG)
    ) dut (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .lcd_wr_i  (lcd_wr_i),
        .lcd_word_i(lcd_word_i),
        .lcd_on_o  (lcd_on_o),
        .lcd_rs_o  (lcd_rs_o),
        .lcd_rw_o  (lcd_rw_o),
        .lcd_en_o  (lcd_en_o),
        .lcd_data_o(lcd_data_o),
        .status_o  (status_o),
        .ovf_clr_i (ovf_clr_i)
    );

    // clock / reset / cycle counter
    always #5 clk_i = ~clk_i;
    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];
    int t0 = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // monitor: pops one expected item per EN pulse
    logic        en_prev = 1'b0;
    int          width = 0;
    int          rise_cyc = 0;
    int          last_rise = 0;
    logic [16:0] item;

    always @(negedge clk_i) begin
        if (!rst_ni) begin
            en_prev = 1'b0;
            width   = 0;
        end else begin
            if (lcd_en_o && !en_prev) begin
                rise_cyc = cyc;
                width    = 1;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got rs/data 0x%0h, expected no pulse",
                             {lcd_rs_o, lcd_data_o});
                end else begin
                    item = exp_q.pop_front();
                    check("pulse_rs_data", {23'h0, lcd_rs_o, lcd_data_o}, {23'h0, item[8:0]});
                    if (item[16:9] != 8'd0)
                        check("pulse_gap", cyc - last_rise, {24'h0, item[16:9]});
                end
                last_rise = cyc;
            end else if (lcd_en_o) begin
                width++;
            end else if (en_prev) begin
                check("pulse_width", width, T_EN_HIGH);
            end
            en_prev = lcd_en_o;
        end
    end

    // driver tasks
    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic strobe(input logic [31:0] w);
        lcd_wr_i   = 1'b1;
        lcd_word_i = w;
        tick();
        lcd_wr_i   = 1'b0;
    endtask

    task automatic expect_pulse(input logic [8:0] rs_data, input logic [7:0] gap);
        exp_q.push_back({gap, rs_data});
    endtask

    // five consecutive RS=1 strobes of base..base+4 with ON=1
    task automatic burst5(input logic [7:0] base);
        for (int i = 0; i < 5; i++) begin
            expect_pulse({1'b1, base + 8'(i)}, (i == 0) ? 8'd0 : 8'd9);
            strobe(32'h8000_0200 | {24'h0, base + 8'(i)});
        end
    endtask

    task automatic wait_idle(input string name, input int exp_rel);
        int n;
        n = 0;
        while (status_o[0] && n < 300) begin
            tick();
            n++;
        end
        check(name, cyc - t0, exp_rel);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("reset_status", status_o, 32'h0);
        check("reset_outputs", {20'h0, lcd_on_o, lcd_rs_o, lcd_rw_o, lcd_en_o, lcd_data_o}, 32'h0);
        rst_ni = 1'b1;
        tick();
        check("post_reset_status", status_o, 32'h0000_0008);

        // single data write
        t0 = cyc;
        expect_pulse(9'h141, 8'd0);
        strobe(32'h8000_0241);
        check("s1_on", {31'h0, lcd_on_o}, 32'h1);
        check("s1_status_c1", status_o, 32'h0000_0011);
        tick();
        check("s1_rs_data_c2", {23'h0, lcd_rs_o, lcd_data_o}, 32'h141);
        check("s1_en_low_c2", {31'h0, lcd_en_o}, 32'h0);
        wait_idle("s1_busy_fall", 10);
        check("s1_en_rise", rise_cyc - t0, 3);
        check("s1_rw", {31'h0, lcd_rw_o}, 32'h0);
        tick();

        // clear command uses the long exec wait
        t0 = cyc;
        expect_pulse(9'h001, 8'd0);
        strobe(32'h8000_0001);
        wait_idle("s2_clear_busy_fall", 16);
        check("s2_clear_rs_data", {23'h0, lcd_rs_o, lcd_data_o}, 32'h001);

        // function set uses the normal exec wait
        t0 = cyc;
        expect_pulse(9'h038, 8'd0);
        strobe(32'h0000_0038);
        check("s2_on_off", {31'h0, lcd_on_o}, 32'h0);
        wait_idle("s2_fset_busy_fall", 10);
        tick();

        // burst and overflow
        t0 = cyc;
        burst5(8'h41);
        check("s3_full_status", status_o, 32'h0000_0043);
        strobe(32'h8000_0246);
        check("s3_ovf_status", status_o, 32'h0000_0047);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        check("s3_ovf_cleared", status_o, 32'h0000_0043);
        wait_idle("s3_busy_fall", 46);
        tick();

        // push and pop in the same cycle while full
        t0 = cyc;
        burst5(8'h50);
        while (cyc - t0 < 10) tick();
        check("s4_full_at_pop", status_o, 32'h0000_0043);
        expect_pulse(9'h155, 8'd9);
        strobe(32'h8000_0255);
        check("s4_count_kept", status_o, 32'h0000_0043);
        wait_idle("s4_busy_fall", 55);
        tick();

        // reset while EN is high with two entries queued
        t0 = cyc;
        strobe(32'h8000_0261);
        strobe(32'h8000_0262);
        strobe(32'h8000_0263);
        check("s5_en_before_reset", {31'h0, lcd_en_o}, 32'h1);
        rst_ni = 1'b0;
        #1;
        check("s5_en_async_drop", {31'h0, lcd_en_o}, 32'h0);
        exp_q.delete();
        tick();
        check("s5_status_in_reset", status_o, 32'h0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("s5_status_after", status_o, 32'h0000_0008);
        for (int i = 0; i < 30; i++) tick();
        check("s5_status_still_empty", status_o, 32'h0000_0008);
        check("s5_rs_data_reset", {23'h0, lcd_rs_o, lcd_data_o}, 32'h0);

        // ON bit updates even when the word is dropped
        t0 = cyc;
        burst5(8'h70);
        check("s6_on_before", {31'h0, lcd_on_o}, 32'h1);
        strobe(32'h0000_0000);
        check("s6_on_dropped", {31'h0, lcd_on_o}, 32'h0);
        check("s6_ovf", status_o, 32'h0000_0047);
        ovf_clr_i = 1'b1;
        tick();
        ovf_clr_i = 1'b0;
        wait_idle("s6_busy_fall", 46);
        tick();
        check("final_status", status_o, 32'h0000_0008);
        check("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
